// File: rtl/timeout_arbiter.sv
// ============================================================================
// timeout_arbiter
// ----------------------------------------------------------------------------
// Shares one down-counter among NREQ requesters. Each requester holds its req
// bit high to ask for a timeout window of len[i] cycles. A round-robin
// arbiter picks one owner in IDLE. The owner then holds grant for the whole
// window and receives a one-cycle timeout_pulse when the window expires.
// The owner can drop req or raise cancel to abandon the window early.
// Deasserting enable returns the block to IDLE at any time.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   CW    counter / window-length width in bits
//
// Ports
//   clock          in   rising-edge clock for all state
//   rst_n          in   asynchronous active-low reset
//   enable         in   global enable; low forces IDLE on the next edge
//   req            in   [NREQ]     per-requester level request
//   cancel         in   [NREQ]     per-requester abort (owner only)
//   len            in   [NREQ*CW]  per-requester window length, slice i at [i*CW +: CW]
//   grant          out  [NREQ]     one-hot owner while counting, else zero
//   timeout_pulse  out  [NREQ]     one-cycle expiry strobe to the owner
//   busy           out             high whenever the FSM is not in IDLE
//   active_id      out  [clog2]    index of the current or most recent owner
// ============================================================================
module timeout_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 32
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           cancel,
    input  logic [NREQ*CW-1:0]        len,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           timeout_pulse,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   active_id
);

    localparam int IDW = $clog2(NREQ);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]     state_q,     state_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic [IDW-1:0] active_id_q, active_id_d;

    // ------------------------------------------------------------------------
    // Round-robin winner search. The search starts one past the last owner so
    // that a requester that just finished goes to the back of the queue.
    // ------------------------------------------------------------------------
    logic           any_req;
    logic           winner_found;
    logic [IDW-1:0] winner_idx;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        winner_found = 1'b0;
        winner_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            cand = int'(active_id_q) + 1 + k;
            // cand is at most 2*NREQ-1, so one subtraction is a full modulo.
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!winner_found && req[cand]) begin
                winner_found = 1'b1;
                winner_idx   = cand[IDW-1:0];
            end
        end
    end

    assign any_req = |req;

    // ------------------------------------------------------------------------
    // Length of the winning requester. A zero length would otherwise make the
    // counter wrap on its first decrement, so it is promoted to one cycle.
    // ------------------------------------------------------------------------
    logic [CW-1:0] len_win;
    logic [CW-1:0] len_load;

    always_comb begin
        len_win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner_idx == IDW'(k)) begin
                len_win = len[k*CW +: CW];
            end
        end
    end

    assign len_load = (len_win == '0) ? CW'(1) : len_win;

    // ------------------------------------------------------------------------
    // Owner abort: only the current owner's cancel and req bits matter here;
    // activity from other requesters cannot disturb a running window.
    // ------------------------------------------------------------------------
    logic owner_abort;

    assign owner_abort = cancel[active_id_q] | ~req[active_id_q];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        active_id_d = active_id_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && any_req && winner_found) begin
                    state_d     = ST_COUNT;
                    cnt_d       = len_load;
                    active_id_d = winner_idx;
                end
            end

            ST_COUNT: begin
                // An abort takes priority over expiry, so a cancel arriving in
                // the last counting cycle suppresses the pulse.
                if (owner_abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Global enable overrides everything; the last owner is remembered so
        // round-robin fairness continues when enable returns.
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers. active_id resets to the last index so that the first
    // search starts at requester 0.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            active_id_q <= IDW'(NREQ - 1);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_id_q <= active_id_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs are decoded from registered state only, so reset clears them
    // immediately and they are glitch-free with respect to the inputs.
    // ------------------------------------------------------------------------
    logic [NREQ-1:0] owner_onehot;

    assign owner_onehot  = NREQ'(1) << active_id_q;
    assign grant         = (state_q == ST_COUNT) ? owner_onehot : '0;
    assign timeout_pulse = (state_q == ST_DONE)  ? owner_onehot : '0;
    assign busy          = (state_q != ST_IDLE);
    assign active_id     = active_id_q;

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_grant_onehot0 : assert property (@(posedge clock) disable iff (!rst_n)
        $onehot0(grant));

    a_pulse_onehot0 : assert property (@(posedge clock) disable iff (!rst_n)
        $onehot0(timeout_pulse));

    a_grant_pulse_exclusive : assert property (@(posedge clock) disable iff (!rst_n)
        (grant & timeout_pulse) == '0);

    a_legal_state : assert property (@(posedge clock) disable iff (!rst_n)
        state_q != 2'd3);

    a_counting_nonzero : assert property (@(posedge clock) disable iff (!rst_n)
        (state_q == ST_COUNT) |-> (cnt_q != '0));

    a_pulse_one_cycle : assert property (@(posedge clock) disable iff (!rst_n)
        (state_q == ST_DONE) |=> (state_q == ST_IDLE));

endmodule

// File: tb/tb_timeout_arbiter.sv
// ============================================================================
// tb_timeout_arbiter
// ----------------------------------------------------------------------------
// Directed bench for timeout_arbiter (NREQ=4, CW=32). Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point, so each
// sample shows the state loaded by the preceding edge.
// ============================================================================
module tb_timeout_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 32;

    logic                   clock;
    logic                   rst_n;
    logic                   enable;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        cancel;
    logic [NREQ*CW-1:0]     len;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        timeout_pulse;
    logic                   busy;
    logic [1:0]             active_id;

    int n_checks = 0;
    int n_fail   = 0;

    timeout_arbiter #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .enable        (enable),
        .req           (req),
        .cancel        (cancel),
        .len           (len),
        .grant         (grant),
        .timeout_pulse (timeout_pulse),
        .busy          (busy),
        .active_id     (active_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 ns before driving or sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_len(input int idx, input logic [CW-1:0] v);
        len[idx*CW +: CW] = v;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [3:0] p, input logic b);
        check({tag, ".grant"}, 64'(grant), 64'(g));
        check({tag, ".pulse"}, 64'(timeout_pulse), 64'(p));
        check({tag, ".busy"},  64'(busy), 64'(b));
    endtask

    task automatic do_reset();
        req    = '0;
        cancel = '0;
        enable = 1'b1;
        rst_n  = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        step();
    endtask

    initial begin
        len = '0;
        do_reset();

        // ---------------- reset state ----------------
        expect_out("reset", 4'b0000, 4'b0000, 1'b0);
        check("reset.active_id", 64'(active_id), 64'd3);

        // ---------------- single requester, len=5 ----------------
        set_len(1, 32'd5);
        req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            step();
            expect_out($sformatf("single.cnt%0d", c), 4'b0010, 4'b0000, 1'b1);
        end
        check("single.active_id", 64'(active_id), 64'd1);
        step();
        expect_out("single.done", 4'b0000, 4'b0010, 1'b1);
        req = 4'b0000;
        step();
        expect_out("single.idle", 4'b0000, 4'b0000, 1'b0);

        // ---------------- len=0 behaves as len=1 ----------------
        set_len(0, 32'd0);
        req = 4'b0001;
        step();
        expect_out("len0.count", 4'b0001, 4'b0000, 1'b1);
        step();
        expect_out("len0.done", 4'b0000, 4'b0001, 1'b1);
        req = 4'b0000;
        step();
        expect_out("len0.idle", 4'b0000, 4'b0000, 1'b0);

        // ---------------- round robin, all len=2 ----------------
        do_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 32'd2);
        req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            logic [3:0] own;
            own = 4'b0001 << (w % NREQ);
            step();
            expect_out($sformatf("rr.w%0d.c0", w), own, 4'b0000, 1'b1);
            step();
            expect_out($sformatf("rr.w%0d.c1", w), own, 4'b0000, 1'b1);
            step();
            expect_out($sformatf("rr.w%0d.done", w), 4'b0000, own, 1'b1);
            if (w == 4) req = 4'b0000;
            step();
            expect_out($sformatf("rr.w%0d.idle", w), 4'b0000, 4'b0000, 1'b0);
        end

        // ---------------- cancel at expiry ----------------
        do_reset();
        set_len(2, 32'd3);
        req = 4'b0100;
        step();
        expect_out("cxl.c3", 4'b0100, 4'b0000, 1'b1);
        step();
        expect_out("cxl.c2", 4'b0100, 4'b0000, 1'b1);
        step();
        expect_out("cxl.c1", 4'b0100, 4'b0000, 1'b1);
        cancel = 4'b0100;
        step();
        expect_out("cxl.idle", 4'b0000, 4'b0000, 1'b0);
        cancel = 4'b0000;
        // req still held: re-grant after a single IDLE cycle
        step();
        expect_out("cxl.regrant", 4'b0100, 4'b0000, 1'b1);
        req = 4'b0000;
        step();
        expect_out("cxl.drop", 4'b0000, 4'b0000, 1'b0);

        // ---------------- enable drop, then async reset ----------------
        do_reset();
        set_len(0, 32'd10);
        req = 4'b0001;
        step();
        step();
        expect_out("en.count", 4'b0001, 4'b0000, 1'b1);
        enable = 1'b0;
        step();
        expect_out("en.off", 4'b0000, 4'b0000, 1'b0);
        check("en.active_id", 64'(active_id), 64'd0);
        enable = 1'b1;
        step();
        expect_out("en.regrant", 4'b0001, 4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst.async", 4'b0000, 4'b0000, 1'b0);
        check("rst.active_id", 64'(active_id), 64'd3);
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        expect_out("rst.after", 4'b0000, 4'b0000, 1'b0);

        // ---------------- non-owner noise ----------------
        set_len(0, 32'd4);
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            expect_out($sformatf("noise.c%0d", c), 4'b0001, 4'b0000, 1'b1);
            if (c < 3 && (c % 2 == 0)) begin
                cancel = 4'b1000;
                req    = 4'b0011;
            end else begin
                cancel = 4'b0000;
                req    = 4'b0001;
            end
        end
        step();
        expect_out("noise.done", 4'b0000, 4'b0001, 1'b1);
        check("noise.active_id", 64'(active_id), 64'd0);
        req = 4'b0000;
        step();
        expect_out("noise.idle", 4'b0000, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
